// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_pkg
//  Purpose  : Shared constants, FSM state type and flat-bus slice helper for
//             the 4x4 cellular-network settle monitor.
//  Revision : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  localparam int WIDTH   = 9;
  localparam int YW      = 2 * WIDTH;   // cell output width, signed
  localparam int FRAC    = 8;           // fractional bits, 1.0 = 1 << FRAC
  localparam int N_CELLS = 16;          // fixed 4x4 array
  localparam int ONE     = 256;         // 1.0 in cell output units

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_TRACK = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Extract cell idx (0-based) from a flat cell bus; cell 0 sits in the LSBs.
  function automatic logic signed [YW-1:0] cell_slice(
    input logic [N_CELLS*YW-1:0] flat,
    input int                    idx
  );
    return flat[idx*YW +: YW];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_cell_stable.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_cell_stable
//  Purpose  : Per-cell stability test (|Y - prev| <= TOL) and sign threshold.
//             Optional macro CNN_SAT_CHECK_EN additionally requires |Y| >= 1.0
//             before a cell may count as stable.
//  Revision : 1.0 - initial release
// ============================================================================
module cnn_cell_stable
  import cnn_pkg::*;
#(
  parameter int TOL = 2
) (
  input  logic signed [YW-1:0] y,
  input  logic signed [YW-1:0] prev,
  output logic                 stable,
  output logic                 nonneg
);

  logic signed [YW:0] w_diff;
  logic        [YW:0] w_mag;
  logic               w_diff_ok;

  // One extra bit so the difference of two extreme samples never wraps.
  assign w_diff    = {y[YW-1], y} - {prev[YW-1], prev};
  assign w_mag     = w_diff[YW] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_diff_ok = (w_mag <= (YW+1)'(TOL));

  // Zero and positive values map to 1, anything negative to 0.
  assign nonneg = ~y[YW-1];

`ifdef CNN_SAT_CHECK_EN
  localparam logic signed [YW-1:0] c_pos_one = ONE[YW-1:0];
  localparam logic signed [YW-1:0] c_neg_one = -c_pos_one;

  logic w_sat;

  // Only cells that have left the linear region may be considered settled.
  assign w_sat  = (y >= c_pos_one) || (y <= c_neg_one);
  assign stable = w_diff_ok && w_sat;
`else
  assign stable = w_diff_ok;
`endif

endmodule
`default_nettype wire

// File: rtl/cnn_settle_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_settle_monitor
//  Purpose  : Tracks the 4x4 cellular-network trajectory after a start pulse,
//             declares convergence after STABLE_CYCLES all-stable samples or
//             aborts at MAX_ITER, then offers the thresholded 16-bit image on
//             a valid/ready handshake.
//             Optional macro CNN_SAT_CHECK_EN (in cnn_cell_stable) restricts
//             stability to saturated cells.
//  Revision : 1.0 - initial release
// ============================================================================
module cnn_settle_monitor
  import cnn_pkg::*;
#(
  parameter int YW            = cnn_pkg::YW,
  parameter int N_CELLS       = cnn_pkg::N_CELLS,
  parameter int TOL           = 2,
  parameter int STABLE_CYCLES = 8,
  parameter int MAX_ITER      = 1023,
  parameter int ITW           = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_CELLS*YW-1:0] y_flat,
  output logic                  busy,
  output logic [N_CELLS-1:0]    mask,
  output logic                  mask_valid,
  input  logic                  mask_ready,
  output logic                  converged,
  output logic [ITW-1:0]        iter_count
);

  localparam int SCW = $clog2(STABLE_CYCLES + 1);

  state_t                  r_state;
  logic [N_CELLS*YW-1:0]   r_prev;
  logic [SCW-1:0]          r_stable_cnt;

  logic [N_CELLS-1:0]      w_stable;
  logic [N_CELLS-1:0]      w_nonneg;
  logic                    w_all_stable;
  logic [SCW-1:0]          w_cnt_inc;
  logic [ITW-1:0]          w_iter_next;
  logic                    w_converge;
  logic                    w_limit;

  genvar gi;
  generate
    for (gi = 0; gi < N_CELLS; gi++) begin : g_cells
      cnn_cell_stable #(
        .TOL (TOL)
      ) u_cell (
        .y      (cell_slice(y_flat, gi)),
        .prev   (cell_slice(r_prev, gi)),
        .stable (w_stable[gi]),
        .nonneg (w_nonneg[gi])
      );
    end
  endgenerate

  assign w_all_stable = &w_stable;
  assign w_cnt_inc    = r_stable_cnt + 1'b1;
  assign w_iter_next  = (&iter_count) ? iter_count : iter_count + 1'b1;
  assign w_converge   = w_all_stable && (w_cnt_inc == SCW'(STABLE_CYCLES));
  // Counts the sample being taken this cycle, so the final count equals MAX_ITER.
  assign w_limit      = (w_iter_next == ITW'(MAX_ITER));

  // Run control FSM with registered outputs; convergence takes priority over abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_prev       <= '0;
      r_stable_cnt <= '0;
      busy         <= 1'b0;
      mask         <= '0;
      mask_valid   <= 1'b0;
      converged    <= 1'b0;
      iter_count   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            iter_count   <= '0;
            r_stable_cnt <= '0;
            converged    <= 1'b0;
            r_state      <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          r_prev     <= y_flat;
          iter_count <= ITW'(1);
          busy       <= 1'b1;
          r_state    <= ST_TRACK;
        end
        ST_TRACK: begin
          r_prev       <= y_flat;
          iter_count   <= w_iter_next;
          r_stable_cnt <= w_all_stable ? w_cnt_inc : '0;
          if (w_converge) begin
            mask       <= w_nonneg;
            converged  <= 1'b1;
            mask_valid <= 1'b1;
            r_state    <= ST_HOLD;
          end else if (w_limit) begin
            mask       <= w_nonneg;
            converged  <= 1'b0;
            mask_valid <= 1'b1;
            r_state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (mask_ready) begin
            mask_valid <= 1'b0;
            busy       <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cnn_settle_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cnn_settle_monitor
//  Purpose  : Directed and randomized trajectories against a sample-list model
//             of the settle monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_settle_monitor;

  localparam int YW   = 18;
  localparam int NC   = 16;
  localparam int TOL  = 2;
  localparam int SC   = 8;
  localparam int MAXI = 1023;
  localparam int ITW  = 16;
  localparam int NSEQ = 1100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              mask_ready = 1'b0;
  logic [NC*YW-1:0]  y_flat = '0;
  logic              busy;
  logic [NC-1:0]     mask;
  logic              mask_valid;
  logic              converged;
  logic [ITW-1:0]    iter_count;

  int vectors = 0;
  int miscompares = 0;

  int          ys [NSEQ][NC];
  int          exp_k;
  logic        exp_conv;
  logic [15:0] exp_mask;

  cnn_settle_monitor #(
    .YW(YW), .N_CELLS(NC), .TOL(TOL), .STABLE_CYCLES(SC), .MAX_ITER(MAXI), .ITW(ITW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y_flat(y_flat), .busy(busy),
    .mask(mask), .mask_valid(mask_valid), .mask_ready(mask_ready),
    .converged(converged), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC*YW-1:0] pack_row(input int t);
    logic [NC*YW-1:0] r;
    int v;
    r = '0;
    for (int c = 0; c < NC; c++) begin
      v = ys[t][c];
      r[c*YW +: YW] = v[YW-1:0];
    end
    return r;
  endfunction

  // Fill ys[t][c] with the trajectory for one run (row t = t-th sample after start).
  task automatic gen_seq(input int mode);
    int pat [NC];
    int c2;
    for (int c = 0; c < NC; c++)
      pat[c] = (c == 5 || c == 6 || c == 9 || c == 10) ? 256 : -256;
    if (mode == 6) begin
      pat[0] = 0;       pat[1] = -1;   pat[2] = -131072; pat[3] = 131071;
      pat[4] = 1;       pat[5] = 255;  pat[6] = -256;    pat[7] = -257;
      for (int c = 8; c < NC; c++) pat[c] = int'($urandom_range(0, 262143)) - 131072;
    end
    if (mode == 7)
      for (int c = 0; c < NC; c++) pat[c] = int'($urandom_range(0, 4000)) - 2000;
    for (int t = 0; t < NSEQ; t++) begin
      for (int c = 0; c < NC; c++) begin
        case (mode)
          1:       ys[t][c] = (c == 0) ? ((t % 2) ? 8 : 0) : pat[c];
          2:       ys[t][c] = pat[c] + 2 * t;
          3:       ys[t][c] = pat[c] + 3 * t;
          4:       ys[t][c] = 128;
          5:       ys[t][c] = (t == 0) ? int'($urandom_range(0, 2000)) - 1000
                                       : ys[t-1][c] + int'($urandom_range(0, 4)) - 2;
          default: ys[t][c] = pat[c];
        endcase
      end
      if (mode == 5 && t > 0 && $urandom_range(0, 11) == 0) begin
        c2 = int'($urandom_range(0, NC - 1));
        ys[t][c2] = ys[t][c2] + int'($urandom_range(5, 40));
      end
    end
  endtask

  // Walk the sample list: row 0 primes, later rows are judged against their predecessor.
  task automatic model();
    int  cnt;
    int  d;
    bit  stable;
    cnt = 0;
    exp_k = -1;
    exp_conv = 1'b0;
    for (int t = 1; t < NSEQ; t++) begin
      stable = 1'b1;
      for (int c = 0; c < NC; c++) begin
        d = ys[t][c] - ys[t-1][c];
        if (d > TOL || d < -TOL) stable = 1'b0;
`ifdef CNN_SAT_CHECK_EN
        if (ys[t][c] < 256 && ys[t][c] > -256) stable = 1'b0;
`endif
      end
      cnt = stable ? cnt + 1 : 0;
      if (cnt == SC) begin
        exp_k = t; exp_conv = 1'b1; break;
      end
      if (t + 1 == MAXI) begin
        exp_k = t; exp_conv = 1'b0; break;
      end
    end
    for (int c = 0; c < NC; c++) exp_mask[c] = (ys[exp_k][c] >= 0);
  endtask

  task automatic run_case(input string tag, input int mode, input int hold);
    int  edges;
    bit  seen;
    logic [NC*YW-1:0] junk;
    gen_seq(mode);
    model();
    @(negedge clk);
    start  = 1'b1;
    y_flat = pack_row(0);
    edges  = 0;
    seen   = 1'b0;
    while (!seen && edges < NSEQ - 2) begin
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
      if (mask_valid) seen = 1'b1;
      else y_flat = pack_row(edges - 1);
    end
    check({tag, ":latency"},   edges,      exp_k + 2);
    check({tag, ":mask"},      mask,       exp_mask);
    check({tag, ":converged"}, converged,  exp_conv);
    check({tag, ":iter"},      iter_count, exp_k + 1);
    check({tag, ":busy"},      busy,       1);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        for (int w = 0; w < NC; w++) junk[w*YW +: YW] = YW'($urandom);
        y_flat = junk;
        start  = (i == hold / 2);
        @(posedge clk); #1;
        start = 1'b0;
      end
      check({tag, ":hold_valid"}, mask_valid, 1);
      check({tag, ":hold_mask"},  mask,       exp_mask);
      check({tag, ":hold_conv"},  converged,  exp_conv);
      check({tag, ":hold_iter"},  iter_count, exp_k + 1);
    end
    mask_ready = 1'b1;
    start = (hold > 0);
    @(posedge clk); #1;
    mask_ready = 1'b0;
    start = 1'b0;
    check({tag, ":ack_valid"}, mask_valid, 0);
    check({tag, ":ack_busy"},  busy,       0);
    check({tag, ":idle_mask"}, mask,       exp_mask);
    check({tag, ":idle_conv"}, converged,  exp_conv);
    if (hold > 0) begin
      repeat (2) @(posedge clk);
      #1;
      check({tag, ":start_ignored"}, busy, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:busy",  busy,       0);
    check("rst:valid", mask_valid, 0);
    check("rst:mask",  mask,       0);
    check("rst:conv",  converged,  0);
    check("rst:iter",  iter_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_case("const",     0, 0);
    run_case("constHold", 0, 20);
    run_case("alt8",      1, 0);
    run_case("drift2",    2, 0);
    run_case("drift3",    3, 0);
    run_case("linear128", 4, 0);
    run_case("edgeVals",  6, 0);
    run_case("randImg",   7, 0);
    for (int r = 0; r < 4; r++) run_case("walk", 5, 0);
    run_case("constPre",  0, 0);

    // Reset in the middle of a tracking run.
    gen_seq(0);
    @(negedge clk);
    start  = 1'b1;
    y_flat = pack_row(0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrun:iter", iter_count, 5);
    check("midrun:busy", busy,       1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst:busy",  busy,       0);
    check("midrst:valid", mask_valid, 0);
    check("midrst:mask",  mask,       0);
    check("midrst:conv",  converged,  0);
    check("midrst:iter",  iter_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_case("afterRst", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
